// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search datapath: key width, checker
// state encoding and the plaintext character filter.
`timescale 1ns/1ps
package rc4_pkg;

  localparam int KEY_W = 24;

  // Printable-plaintext alphabet accepted by the checker
  localparam logic [7:0] CHAR_LO = 8'h61;  // 'a'
  localparam logic [7:0] CHAR_HI = 8'h7A;  // 'z'
  localparam logic [7:0] CHAR_SP = 8'h20;  // ' '

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CHECK,
    RELEASE,
    FOUND
  } state_t;

  // A decrypted byte is plausible plaintext when it is a lower-case letter or a space
  function automatic logic char_is_valid(input logic [7:0] c);
    return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
  endfunction

endpackage

// File: rtl/key_checker.sv
// Walks the decrypted message RAM for one candidate key, byte by byte.
// The first non-plaintext byte returns a one-cycle TAK to the key counter;
// a message that is entirely plaintext latches the key and stops the search.
`timescale 1ns/1ps
module key_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              TAK,
  output logic              found,
  output logic [KEY_W-1:0]  found_key,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  index_q, index_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               tak_q, tak_d;
  logic               found_q, found_d;
  logic [KEY_W-1:0]   found_key_q, found_key_d;
  logic               busy_q, busy_d;
  logic [KEY_W-1:0]   key_q, key_d;

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    rd_addr_d   = rd_addr_q;
    tak_d       = 1'b0;
    found_d     = found_q;
    found_key_d = found_key_q;
    key_d       = key_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Latch the key so later changes on the input cannot affect this check
          key_d     = key;
          index_d   = '0;
          rd_addr_d = '0;
          state_d   = ADDR;
        end
      end

      ADDR: begin
        // rd_addr already carries index here; the RAM samples it on this edge
        rd_addr_d = index_q;
        state_d   = WAIT;
      end

      WAIT: begin
        state_d = CHECK;
      end

      CHECK: begin
        if (!char_is_valid(rd_data)) begin
          tak_d   = 1'b1;
          state_d = RELEASE;
        end else if (index_q == LAST_IDX) begin
          found_d     = 1'b1;
          found_key_d = key_q;
          state_d     = FOUND;
        end else begin
          index_d   = index_q + IDX_ONE;
          rd_addr_d = index_q + IDX_ONE;
          state_d   = ADDR;
        end
      end

      RELEASE: begin
        // Hold until the request level drops so one start is never checked twice
        if (!start) begin
          state_d = IDLE;
        end
      end

      FOUND: begin
        state_d = FOUND;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) && (state_d != FOUND);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      rd_addr_q   <= '0;
      tak_q       <= 1'b0;
      found_q     <= 1'b0;
      found_key_q <= '0;
      busy_q      <= 1'b0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      rd_addr_q   <= rd_addr_d;
      tak_q       <= tak_d;
      found_q     <= found_d;
      found_key_q <= found_key_d;
      busy_q      <= busy_d;
      key_q       <= key_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign TAK       = tak_q;
  assign found     = found_q;
  assign found_key = found_key_q;
  assign busy      = busy_q;

endmodule
